// File: rtl/memory_pkg.sv
// Shared pipeline definitions: writeback source encodings, M-stage FSM states
// and the layout of the M-stage pipeline register.
package memory_pkg;

  localparam logic [1:0] WB_SRC_ALU = 2'b00;
  localparam logic [1:0] WB_SRC_MEM = 2'b01;
  localparam logic [1:0] WB_SRC_PC4 = 2'b10;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    REQ   = 2'd1,
    WAIT  = 2'd2,
    DRAIN = 2'd3
  } m_state_t;

  typedef struct packed {
    logic        pc_write;
    logic        rd_write;
    logic        mem_write;
    logic [1:0]  rd_write_src;
    logic [4:0]  rd;
    logic [31:0] pc;
    logic [31:0] alu_res;
    logic [31:0] mem_data;
  } m_regs_t;

  // Loads are identified by their writeback source; reserved code 11 is not a load.
  function automatic logic is_mem_op(input logic mem_write, input logic [1:0] src);
    return mem_write || (src == WB_SRC_MEM);
  endfunction

endpackage

// File: rtl/dmem_if.sv
// Data-memory port: valid/grant request channel plus rvalid load-response channel.
interface dmem_if;
  logic        req;
  logic        we;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        gnt;
  logic        rvalid;
  logic [31:0] rdata;

  modport master (output req, we, addr, wdata, input gnt, rvalid, rdata);
  modport slave  (input req, we, addr, wdata, output gnt, rvalid, rdata);
endinterface

// File: rtl/dmem_port.sv
// M-stage bus sequencer: issues one word access per mem op and tracks the
// outstanding load response, including responses owed after a flush.
module dmem_port
  import memory_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        flush_m,
  input  logic        mem_write_m,
  input  logic [31:0] alu_res_m,
  input  logic [31:0] mem_data_m,
  output logic        busy_m,
  output logic [31:0] mem_rdata_m,
  dmem_if.master      dmem
);

  m_state_t    state_reg, state_next;
  logic [31:0] rdata_reg, rdata_next;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= IDLE;
      rdata_reg <= '0;
    end else begin
      state_reg <= state_next;
      rdata_reg <= rdata_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    rdata_next = rdata_reg;
    case (state_reg)
      IDLE:  state_next = start ? REQ : IDLE;
      REQ: begin
        // A grant is always honoured, even alongside a flush.
        if (dmem.gnt)
          state_next = mem_write_m ? IDLE : (flush_m ? DRAIN : WAIT);
        else if (flush_m)
          state_next = IDLE;
      end
      WAIT: begin
        if (dmem.rvalid) begin
          state_next = IDLE;
          if (!flush_m)
            rdata_next = dmem.rdata;
        end else if (flush_m) begin
          state_next = DRAIN;
        end
      end
      DRAIN: if (dmem.rvalid) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  assign busy_m      = (state_reg != IDLE);
  assign mem_rdata_m = rdata_reg;
  assign dmem.req    = (state_reg == REQ);
  assign dmem.we     = (state_reg == REQ) && mem_write_m;
  assign dmem.addr   = alu_res_m & 32'hFFFF_FFFC;
  assign dmem.wdata  = mem_data_m;

endmodule

// File: rtl/memory.sv
// MEMORY pipeline stage: the E->M pipeline register plus the data-memory port.
module memory
  import memory_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        pc_write_e,
  input  logic        rd_write_e,
  input  logic        mem_write_e,
  input  logic [1:0]  rd_write_src_e,
  input  logic [4:0]  rd_e,
  input  logic [31:0] pc_e,
  input  logic [31:0] alu_res_e,
  input  logic [31:0] mem_data_e,
  input  logic        stall_m,
  input  logic        flush_m,
  output logic        busy_m,
  dmem_if.master      dmem,
  output logic        pc_write_m,
  output logic        rd_write_m,
  output logic [1:0]  rd_write_src_m,
  output logic [4:0]  rd_m,
  output logic [31:0] pc_m,
  output logic [31:0] alu_res_m,
  output logic [31:0] mem_rdata_m
);

  m_regs_t pipe_reg, pipe_next;
  logic    adv;
  logic    start;

  assign adv   = !busy_m && !stall_m;
  assign start = adv && !flush_m && is_mem_op(mem_write_e, rd_write_src_e);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) pipe_reg <= '0;
    else     pipe_reg <= pipe_next;
  end

  // Flush wins over both advance and hold so a squashed op never reaches writeback.
  always_comb begin
    pipe_next = pipe_reg;
    if (flush_m) begin
      pipe_next = '0;
    end else if (adv) begin
      pipe_next.pc_write     = pc_write_e;
      pipe_next.rd_write     = rd_write_e;
      pipe_next.mem_write    = mem_write_e;
      pipe_next.rd_write_src = rd_write_src_e;
      pipe_next.rd           = rd_e;
      pipe_next.pc           = pc_e;
      pipe_next.alu_res      = alu_res_e;
      pipe_next.mem_data     = mem_data_e;
    end
  end

  dmem_port u_dmem_port (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .flush_m     (flush_m),
    .mem_write_m (pipe_reg.mem_write),
    .alu_res_m   (pipe_reg.alu_res),
    .mem_data_m  (pipe_reg.mem_data),
    .busy_m      (busy_m),
    .mem_rdata_m (mem_rdata_m),
    .dmem        (dmem)
  );

  assign pc_write_m     = pipe_reg.pc_write;
  assign rd_write_m     = pipe_reg.rd_write;
  assign rd_write_src_m = pipe_reg.rd_write_src;
  assign rd_m           = pipe_reg.rd;
  assign pc_m           = pipe_reg.pc;
  assign alu_res_m      = pipe_reg.alu_res;

endmodule

// File: tb/tb_memory.sv
// Directed bench for the MEMORY stage: a transaction-level model checked every
// cycle, plus hand-computed expectations at key points of each scenario.
module tb_memory;

  logic        clk, rst;
  logic        pc_write_e, rd_write_e, mem_write_e;
  logic [1:0]  rd_write_src_e;
  logic [4:0]  rd_e;
  logic [31:0] pc_e, alu_res_e, mem_data_e;
  logic        stall_m, flush_m;
  logic        busy_m;
  logic        pc_write_m, rd_write_m;
  logic [1:0]  rd_write_src_m;
  logic [4:0]  rd_m;
  logic [31:0] pc_m, alu_res_m, mem_rdata_m;

  dmem_if bus ();

  memory dut (
    .clk            (clk),
    .rst            (rst),
    .pc_write_e     (pc_write_e),
    .rd_write_e     (rd_write_e),
    .mem_write_e    (mem_write_e),
    .rd_write_src_e (rd_write_src_e),
    .rd_e           (rd_e),
    .pc_e           (pc_e),
    .alu_res_e      (alu_res_e),
    .mem_data_e     (mem_data_e),
    .stall_m        (stall_m),
    .flush_m        (flush_m),
    .busy_m         (busy_m),
    .dmem           (bus),
    .pc_write_m     (pc_write_m),
    .rd_write_m     (rd_write_m),
    .rd_write_src_m (rd_write_src_m),
    .rd_m           (rd_m),
    .pc_m           (pc_m),
    .alu_res_m      (alu_res_m),
    .mem_rdata_m    (mem_rdata_m)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Model: which instruction sits in M, whether a request is pending on the
  // bus, whether a load response is still owed and whether it will be kept.
  typedef struct packed {
    logic        pend;
    logic        owed;
    logic        keep;
    logic        mw;
    logic        pcw;
    logic        rdw;
    logic [1:0]  src;
    logic [4:0]  rd;
    logic [31:0] pc;
    logic [31:0] alu;
    logic [31:0] md;
    logic [31:0] rdata;
  } model_t;

  model_t x;

  function automatic model_t model_step(input model_t c);
    model_t n;
    logic   occupied;
    n = c;
    occupied = c.pend || c.owed;
    if (c.pend) begin
      if (bus.gnt) begin
        n.pend = 1'b0;
        if (!c.mw) begin
          n.owed = 1'b1;
          n.keep = !flush_m;
        end
      end else if (flush_m) begin
        n.pend = 1'b0;
      end
    end else if (c.owed) begin
      if (bus.rvalid) begin
        n.owed = 1'b0;
        if (c.keep && !flush_m) n.rdata = bus.rdata;
      end else if (flush_m) begin
        n.keep = 1'b0;
      end
    end
    if (flush_m) begin
      n.mw = 0; n.pcw = 0; n.rdw = 0; n.src = 0; n.rd = 0; n.pc = 0; n.alu = 0; n.md = 0;
    end else if (!occupied && !stall_m) begin
      n.mw = mem_write_e; n.pcw = pc_write_e; n.rdw = rd_write_e; n.src = rd_write_src_e;
      n.rd = rd_e; n.pc = pc_e; n.alu = alu_res_e; n.md = mem_data_e;
      if (mem_write_e || rd_write_src_e == 2'b01) n.pend = 1'b1;
    end
    return n;
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) x <= '0;
    else     x <= model_step(x);
  end

  always @(negedge clk) begin
    if (!rst) begin
      chk("alu_res_m", alu_res_m, x.alu);
      chk("rd_m", {27'd0, rd_m}, {27'd0, x.rd});
      chk("rd_write_m", {31'd0, rd_write_m}, {31'd0, x.rdw});
      chk("pc_write_m", {31'd0, pc_write_m}, {31'd0, x.pcw});
      chk("rd_write_src_m", {30'd0, rd_write_src_m}, {30'd0, x.src});
      chk("pc_m", pc_m, x.pc);
      chk("mem_rdata_m", mem_rdata_m, x.rdata);
      chk("busy_m", {31'd0, busy_m}, {31'd0, x.pend || x.owed});
      chk("dmem_req", {31'd0, bus.req}, {31'd0, x.pend});
      chk("dmem_wdata", bus.wdata, x.md);
      if (x.pend) begin
        chk("dmem_we", {31'd0, bus.we}, {31'd0, x.mw});
        chk("dmem_addr", bus.addr, {x.alu[31:2], 2'b00});
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_e();
    pc_write_e = 0; rd_write_e = 0; mem_write_e = 0; rd_write_src_e = 2'b00;
    rd_e = 0; pc_e = 0; alu_res_e = 0; mem_data_e = 0;
  endtask

  task automatic send_load(input logic [31:0] addr, input logic [4:0] rd);
    alu_res_e = addr; rd_e = rd; rd_write_e = 1; rd_write_src_e = 2'b01;
    step();
    clear_e();
  endtask

  initial begin
    rst = 1; stall_m = 0; flush_m = 0;
    bus.gnt = 0; bus.rvalid = 0; bus.rdata = 0;
    clear_e();
    step(); step();
    chk("reset busy_m", {31'd0, busy_m}, 32'd0);
    chk("reset dmem_req", {31'd0, bus.req}, 32'd0);
    chk("reset alu_res_m", alu_res_m, 32'd0);
    chk("reset mem_rdata_m", mem_rdata_m, 32'd0);
    rst = 0;

    // ALU op
    alu_res_e = 32'h1234; rd_e = 5; rd_write_e = 1; pc_write_e = 1; pc_e = 32'h80;
    step();
    clear_e();
    chk("alu alu_res_m", alu_res_m, 32'h1234);
    chk("alu rd_m", {27'd0, rd_m}, 32'd5);
    chk("alu busy_m", {31'd0, busy_m}, 32'd0);
    chk("alu dmem_req", {31'd0, bus.req}, 32'd0);
    $display("[TB] alu op 0x1234 -> rd 5");

    // Store, granted in the first REQ cycle
    alu_res_e = 32'h103; mem_data_e = 32'hDEADBEEF; mem_write_e = 1; bus.gnt = 1;
    step();
    clear_e();
    chk("st dmem_req", {31'd0, bus.req}, 32'd1);
    chk("st dmem_we", {31'd0, bus.we}, 32'd1);
    chk("st dmem_addr", bus.addr, 32'h100);
    chk("st dmem_wdata", bus.wdata, 32'hDEADBEEF);
    chk("st busy_m", {31'd0, busy_m}, 32'd1);
    step();
    bus.gnt = 0;
    chk("st idle busy_m", {31'd0, busy_m}, 32'd0);
    chk("st idle dmem_req", {31'd0, bus.req}, 32'd0);
    $display("[TB] store 0xDEADBEEF @0x100");

    // Load: grant on the second REQ cycle, rvalid one cycle later
    send_load(32'h200, 5'd7);
    chk("ld busy c1", {31'd0, busy_m}, 32'd1);
    chk("ld we", {31'd0, bus.we}, 32'd0);
    step();
    chk("ld busy c2", {31'd0, busy_m}, 32'd1);
    bus.gnt = 1;
    step();
    bus.gnt = 0;
    chk("ld busy c3", {31'd0, busy_m}, 32'd1);
    chk("ld wait req", {31'd0, bus.req}, 32'd0);
    bus.rvalid = 1; bus.rdata = 32'hCAFEF00D;
    step();
    bus.rvalid = 0;
    chk("ld busy done", {31'd0, busy_m}, 32'd0);
    chk("ld mem_rdata_m", mem_rdata_m, 32'hCAFEF00D);
    chk("ld rd_write_src_m", {30'd0, rd_write_src_m}, 32'd1);
    $display("[TB] load @0x200 -> 0x%h", mem_rdata_m);

    // Flush while a load is waiting for its response
    send_load(32'h300, 5'd9);
    bus.gnt = 1;
    step();
    bus.gnt = 0;
    flush_m = 1;
    step();
    flush_m = 0;
    chk("fw rd_write_m", {31'd0, rd_write_m}, 32'd0);
    chk("fw busy_m", {31'd0, busy_m}, 32'd1);
    step();
    chk("fw busy_m hold", {31'd0, busy_m}, 32'd1);
    bus.rvalid = 1; bus.rdata = 32'h1111_1111;
    step();
    bus.rvalid = 0;
    chk("fw busy_m done", {31'd0, busy_m}, 32'd0);
    chk("fw mem_rdata_m", mem_rdata_m, 32'hCAFEF00D);
    $display("[TB] load @0x300 flushed in WAIT, response drained");

    // Flush while a load request is still ungranted
    send_load(32'h400, 5'd10);
    chk("fr dmem_req", {31'd0, bus.req}, 32'd1);
    flush_m = 1;
    step();
    flush_m = 0;
    chk("fr dmem_req drop", {31'd0, bus.req}, 32'd0);
    chk("fr busy_m", {31'd0, busy_m}, 32'd0);
    $display("[TB] load @0x400 flushed in REQ");

    // Stall holds an ALU op in M
    alu_res_e = 32'hAAAA; rd_e = 3; rd_write_e = 1;
    step();
    alu_res_e = 32'hBBBB; rd_e = 4; stall_m = 1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("stall alu_res_m", alu_res_m, 32'hAAAA);
      chk("stall rd_m", {27'd0, rd_m}, 32'd3);
    end
    stall_m = 0;
    step();
    clear_e();
    chk("release alu_res_m", alu_res_m, 32'hBBBB);
    chk("release rd_m", {27'd0, rd_m}, 32'd4);
    $display("[TB] stall 3 cycles, then alu op 0xBBBB -> rd 4");

    step(); step();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/memory.md
# memory

MEMORY (_m) pipeline stage. Registers the execute-stage outputs and performs word loads and stores on a valid/grant/rvalid data-memory port. While a bus transaction is outstanding, it raises `busy_m` so the hazard unit can stall the front of the pipe. It forwards `alu_res_m` back to execute and feeds the writeback stage.

## Interface
- No parameters. Data width is fixed at 32 bits; only word accesses are supported.
- `clk`  in  1  rising-edge clock
- `rst`  in  1  asynchronous, active-high reset
- `pc_write_e, rd_write_e, mem_write_e`  in  1 each  control from execute
- `rd_write_src_e`  in  2  writeback source: 00 = ALU, 01 = load data, 10 = pc+4, 11 = reserved (treated as ALU)
- `rd_e`  in  5  destination register
- `pc_e, alu_res_e, mem_data_e`  in  32 each  pc, ALU result / address, store data
- `stall_m`  in  1  hazard unit hold for this stage
- `flush_m`  in  1  hazard unit: load a bubble
- `busy_m`  out  1  transaction outstanding; hazard unit must stall E/D/F
- `dmem_req`  out  1  request valid
- `dmem_we`  out  1  1 = store
- `dmem_addr`  out  32  `{alu_res_m[31:2], 2'b00}`
- `dmem_wdata`  out  32  equals `mem_data_m`
- `dmem_gnt`  in  1  request accepted
- `dmem_rvalid`  in  1  load data valid
- `dmem_rdata`  in  32  load data
- `pc_write_m, rd_write_m`  out  1 each  to writeback / fetch
- `rd_write_src_m`  out  2  to writeback
- `rd_m`  out  5  to writeback / hazard unit
- `pc_m, alu_res_m, mem_rdata_m`  out  32 each  to writeback; `alu_res_m` is also forwarded to execute

## Operation
- Memory operation (mem op) = `mem_write_m` = 1 or `rd_write_src_m` = 01.
- **Pipeline register advance:** `adv = !busy_m && !stall_m`.
  - If `flush_m` = 1: all M registers load 0 (bubble). This has priority over `adv` and `stall_m`.
  - Else if `adv`: the registers capture the `_e` inputs.
  - Else: the registers hold.
- **FSM states:** IDLE, REQ, WAIT, DRAIN.
  - From IDLE or REQ-completed, on a load of a non-bubble mem op (no flush): go to REQ; otherwise go to IDLE.
  - REQ: `dmem_req` = 1, `dmem_we` = `mem_write_m`.
    - On `dmem_gnt`, a store goes to IDLE and is complete.
    - On `dmem_gnt`, a load goes to WAIT.
    - If `flush_m` arrives before `dmem_gnt`: drop the request (no grant is taken) and go to IDLE.
  - WAIT: on `dmem_rvalid`, capture `dmem_rdata` into `mem_rdata_m` and go to IDLE. If `flush_m` occurs in WAIT, go to DRAIN (the response is still owed).
  - DRAIN: on `dmem_rvalid`, discard the data and go to IDLE.
- `busy_m = (state == REQ) || (state == WAIT) || (state == DRAIN)`.
- `mem_rdata_m` is written only on accepted load data and holds otherwise.
- Address bits [1:0] are ignored; there is no misalignment trap in this block.

## Timing
- Reset: every output register and `mem_rdata_m` is 0, state is IDLE, `dmem_req` is 0, and `busy_m` is 0.
- Non-mem instruction: one cycle in M; outputs are valid the cycle after capture.
- Store with `gnt` in the first REQ cycle: `busy_m` is high for 1 cycle, then the pipe advances.
- Load: REQ (≥1 cycle) plus WAIT (≥1 cycle). `dmem_rvalid` is never asserted in the same cycle as `dmem_gnt`.
- `busy_m` is combinational from state only (no input-to-output path).
- Forwarding: `alu_res_m` is stable for the whole time the instruction occupies M, including while stalled.
- `flush_m` together with `dmem_gnt` in REQ: the grant is taken. A store is treated as complete and the state goes to IDLE; a load goes to DRAIN.
- `rst` mid-transaction: return immediately to IDLE. Bus-side recovery is the memory's responsibility.

## Structure
- Shared pipeline package holds:
  - the `rd_write_src` encodings: WB_SRC_ALU = 00, WB_SRC_MEM = 01, WB_SRC_PC4 = 10
  - the M-stage FSM state encoding: IDLE = 0, REQ = 1, WAIT = 2, DRAIN = 3
- One sub-module, `dmem_port`, holds the FSM and the `dmem_*` handshake. The `memory` top level holds the pipeline register.

## Test plan
- **Reset with ALU op:** pulse `rst`, then send `alu_res_e` = 0x1234, `rd_e` = 5, `rd_write_e` = 1 → next cycle `alu_res_m` = 0x1234, `rd_m` = 5, `busy_m` = 0, `dmem_req` = 0.
- **Store, immediate grant:** store with `alu_res_e` = 0x103, `mem_data_e` = 0xDEADBEEF, `gnt` = 1 → one cycle with `dmem_req` = 1, `dmem_we` = 1, `dmem_addr` = 0x100, `busy_m` = 1; idle after.
- **Load, latency 3:** load with `gnt` after 2 cycles and `rvalid` 1 cycle later, `rdata` = 0xCAFEF00D → `busy_m` high for 3 cycles, `mem_rdata_m` = 0xCAFEF00D, `rd_write_src_m` = 01.
- **Flush in WAIT:** `flush_m` while a load is in WAIT → bubble (`rd_write_m` = 0), `busy_m` stays 1 until `rvalid`, and `mem_rdata_m` is unchanged.
- **Flush in REQ before grant:** → `dmem_req` drops next cycle and `busy_m` = 0.
- **`stall_m` with ALU op:** hold `stall_m` for 3 cycles → `alu_res_m` / `rd_m` unchanged; new inputs are not captured until release.
